// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute/writeback stage.
// Holds the fixed datapath width, the ALU select codes and the stage FSM
// state encoding used by alu_exec_stage and its register file.
package alu_exec_stage_pkg;

    // Datapath width is set by the attached 8-bit ALU.
    localparam int WIDTH = 8;

    // ALU select codes driven on alu_s.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // Stage FSM states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_stage_regfile.sv
// exec_regfile: 2**REG_AW x WIDTH register storage for the execute stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low clear of all entries
//   we, waddr, wdata    synchronous write port
//   ra_addr / ra_data   combinational read port A
//   rb_addr / rb_data   combinational read port B
//   dbg_addr / dbg_data combinational debug read port
import alu_exec_stage_pkg::*;

module exec_regfile #(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int NREG = 2 ** REG_AW;

    logic [WIDTH-1:0] regs_r [NREG];

    // Storage array: cleared on reset, one write per cycle when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign ra_data  = regs_r[ra_addr];
    assign rb_data  = regs_r[rb_addr];
    assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/writeback stage wrapped around an external 8-bit
// combinational ALU. Accepts one instruction at a time (valid/ready), reads
// both sources at accept, presents registered operands to the ALU, captures
// result and carry, writes back, and maintains carry/zero flags.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                instruction handshake (ready only in IDLE)
//   in_ld,in_op,in_rd,in_rs,in_rt,in_imm  instruction fields
//   alu_a, alu_b, alu_s              registered ALU operands/select
//   alu_d, alu_c                     ALU result and carry-out
//   done                             one-cycle pulse after writeback
//   flag_c, flag_z                   carry and zero flags
//   dbg_addr / dbg_data              combinational register debug read
import alu_exec_stage_pkg::*;

module alu_exec_stage #(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ld,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [WIDTH-1:0]  in_imm,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_s,
    input  logic [WIDTH-1:0]  alu_d,
    input  logic              alu_c,
    output logic              done,
    output logic              flag_c,
    output logic              flag_z,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic                ld_r;
    logic [REG_AW-1:0]   rd_r;
    logic [WIDTH-1:0]    imm_r;
    logic [WIDTH-1:0]    alu_a_r;
    logic [WIDTH-1:0]    alu_b_r;
    logic [2:0]          alu_s_r;
    logic [WIDTH-1:0]    res_r;
    logic                cres_r;
    logic                done_r;
    logic                flag_c_r;
    logic                flag_z_r;
    logic [WIDTH-1:0]    rs_data_s;
    logic [WIDTH-1:0]    rt_data_s;
    logic [WIDTH-1:0]    wb_data_s;
    logic                wb_en_s;

    exec_regfile #(.REG_AW(REG_AW)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_en_s),
        .waddr    (rd_r),
        .wdata    (wb_data_s),
        .ra_addr  (in_rs),
        .ra_data  (rs_data_s),
        .rb_addr  (in_rt),
        .rb_data  (rt_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Writeback source: loads bypass the ALU with the latched immediate.
    always_comb begin
        wb_en_s = (state_r == WB);
        if (ld_r) begin
            wb_data_s = imm_r;
        end else begin
            wb_data_s = res_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; loads skip EXEC, the unused encoding recovers to IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = in_ld ? WB : EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC:    state_nxt_s = WB;
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath registers: operand capture at accept, result capture in EXEC,
    // flag update and done pulse in WB. Operands hold outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_r     <= 1'b0;
            rd_r     <= {REG_AW{1'b0}};
            imm_r    <= {WIDTH{1'b0}};
            alu_a_r  <= {WIDTH{1'b0}};
            alu_b_r  <= {WIDTH{1'b0}};
            alu_s_r  <= 3'b000;
            res_r    <= {WIDTH{1'b0}};
            cres_r   <= 1'b0;
            done_r   <= 1'b0;
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        ld_r    <= in_ld;
                        rd_r    <= in_rd;
                        imm_r   <= in_imm;
                        alu_a_r <= rs_data_s;
                        alu_b_r <= rt_data_s;
                        alu_s_r <= in_op;
                    end
                end
                EXEC: begin
                    res_r  <= alu_d;
                    cres_r <= alu_c;
                end
                WB: begin
                    flag_z_r <= (wb_data_s == {WIDTH{1'b0}});
                    flag_c_r <= ld_r ? 1'b0 : cres_r;
                    done_r   <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state_r == IDLE);
    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_s    = alu_s_r;
    assign done     = done_r;
    assign flag_c   = flag_c_r;
    assign flag_z   = flag_z_r;

endmodule
